// File: rtl/sysid_ctrl_pkg.sv
// rtl/sysid_ctrl_pkg.sv - shared types and constants for the sysid check controller
package sysid_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ID,
        ST_RD_TS,
        ST_EVAL,
        ST_RETRY
    } state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/sysid_check_ctrl_if.sv
// rtl/sysid_check_ctrl_if.sv - Avalon-MM read port between the checker and the sysid slave
interface sysid_check_ctrl_if;
    import sysid_ctrl_pkg::*;

    logic  avm_address;
    logic  avm_read;
    word_t avm_readdata;
    logic  avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_readdata,
        output avm_waitrequest
    );

endinterface

// File: rtl/sysid_ctrl_timeout.sv
// rtl/sysid_ctrl_timeout.sv - per-read waitrequest counter with expiry flag
module sysid_ctrl_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags the stall that would make the count reach the limit, so the read drops on that edge.
    assign expired = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sysid_check_ctrl.sv
// rtl/sysid_check_ctrl.sv - sysid read/compare sequencer; SYSID_CHECK_RETRY_EN enables retries
module sysid_check_ctrl
    import sysid_ctrl_pkg::*;
#(
    parameter word_t EXPECTED_ID    = 32'd989198131,
    parameter word_t EXPECTED_TS    = 32'd1317257525,
    parameter int    TIMEOUT_CYCLES = 255,
    parameter int    MAX_RETRIES    = 3,
    localparam int   RCW            = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    sysid_check_ctrl_if.master    avm,
    output logic                  busy,
    output logic                  done,
    output logic                  id_ok,
    output logic                  ts_ok,
    output logic                  timeout_err,
    output word_t                 id_value,
    output word_t                 ts_value,
    output logic [RCW-1:0]        retry_count
);

    state_e state_q, state_d;
    logic   auto_start_q, auto_start_d;
    logic   busy_q, busy_d, done_q, done_d;
    logic   id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, to_err_q, to_err_d;
    word_t  id_value_q, id_value_d, ts_value_q, ts_value_d;
    logic   rd_q, rd_d, addr_q, addr_d;
    logic   tmo_clr, tmo_en, tmo_expired;
    logic   id_match, ts_match;
`ifdef SYSID_CHECK_RETRY_EN
    logic [RCW-1:0] rc_q, rc_d;
`endif

    sysid_ctrl_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    assign id_match = !to_err_q && (id_value_q == EXPECTED_ID);
    assign ts_match = !to_err_q && (ts_value_q == EXPECTED_TS);

    always_comb begin
        state_d      = state_q;
        auto_start_d = auto_start_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        id_ok_d      = id_ok_q;
        ts_ok_d      = ts_ok_q;
        to_err_d     = to_err_q;
        id_value_d   = id_value_q;
        ts_value_d   = ts_value_q;
        rd_d         = rd_q;
        addr_d       = addr_q;
        tmo_clr      = 1'b0;
        tmo_en       = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
        rc_d         = rc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped, not deferred.
                if ((start && !done_q) || auto_start_q) begin
                    state_d      = ST_RD_ID;
                    auto_start_d = 1'b0;
                    id_ok_d      = 1'b0;
                    ts_ok_d      = 1'b0;
                    to_err_d     = 1'b0;
                    busy_d       = 1'b1;
                    rd_d         = 1'b1;
                    addr_d       = SYSID_ADDR_ID;
                    tmo_clr      = 1'b1;
`ifdef SYSID_CHECK_RETRY_EN
                    rc_d         = '0;
`endif
                end
            end
            ST_RD_ID: begin
                tmo_en = avm.avm_waitrequest;
                if (!avm.avm_waitrequest) begin
                    id_value_d = avm.avm_readdata;
                    addr_d     = SYSID_ADDR_TS;
                    tmo_clr    = 1'b1;
                    state_d    = ST_RD_TS;
                end else if (tmo_expired) begin
                    rd_d     = 1'b0;
                    to_err_d = 1'b1;
                    state_d  = ST_EVAL;
                end
            end
            ST_RD_TS: begin
                tmo_en = avm.avm_waitrequest;
                if (!avm.avm_waitrequest) begin
                    ts_value_d = avm.avm_readdata;
                    rd_d       = 1'b0;
                    state_d    = ST_EVAL;
                end else if (tmo_expired) begin
                    rd_d     = 1'b0;
                    to_err_d = 1'b1;
                    state_d  = ST_EVAL;
                end
            end
            ST_EVAL: begin
                state_d = ST_IDLE;
                id_ok_d = id_match;
                ts_ok_d = ts_match;
                done_d  = 1'b1;
                busy_d  = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
                if (!(id_match && ts_match) && (int'(rc_q) < MAX_RETRIES)) begin
                    state_d = ST_RETRY;
                    id_ok_d = 1'b0;
                    ts_ok_d = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                end
`endif
            end
`ifdef SYSID_CHECK_RETRY_EN
            ST_RETRY: begin
                rc_d     = rc_q + RCW'(1);
                to_err_d = 1'b0;
                rd_d     = 1'b1;
                addr_d   = SYSID_ADDR_ID;
                tmo_clr  = 1'b1;
                state_d  = ST_RD_ID;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            auto_start_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            id_ok_q      <= 1'b0;
            ts_ok_q      <= 1'b0;
            to_err_q     <= 1'b0;
            id_value_q   <= '0;
            ts_value_q   <= '0;
            rd_q         <= 1'b0;
            addr_q       <= SYSID_ADDR_ID;
`ifdef SYSID_CHECK_RETRY_EN
            rc_q         <= '0;
`endif
        end else begin
            state_q      <= state_d;
            auto_start_q <= auto_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            id_ok_q      <= id_ok_d;
            ts_ok_q      <= ts_ok_d;
            to_err_q     <= to_err_d;
            id_value_q   <= id_value_d;
            ts_value_q   <= ts_value_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
`ifdef SYSID_CHECK_RETRY_EN
            rc_q         <= rc_d;
`endif
        end
    end

    assign avm.avm_read    = rd_q;
    assign avm.avm_address = addr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign timeout_err     = to_err_q;
    assign id_value        = id_value_q;
    assign ts_value        = ts_value_q;
`ifdef SYSID_CHECK_RETRY_EN
    assign retry_count     = rc_q;
`else
    assign retry_count     = '0;
`endif

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb/tb_sysid_check_ctrl.sv - directed and randomized check of sysid_check_ctrl against a run-level model
module tb_sysid_check_ctrl;
    import sysid_ctrl_pkg::*;

    localparam word_t EXP_ID = 32'd989198131;
    localparam word_t EXP_TS = 32'd1317257525;
    localparam int    TMO    = 4;
    localparam int    MAXR   = 3;
    localparam int    RCW    = $clog2(MAXR + 1);
`ifdef SYSID_CHECK_RETRY_EN
    localparam int    ATTEMPTS = MAXR + 1;
`else
    localparam int    ATTEMPTS = 1;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           busy, done, id_ok, ts_ok, timeout_err;
    word_t          id_value, ts_value;
    logic [RCW-1:0] retry_count;

    sysid_check_ctrl_if bus ();

    sysid_check_ctrl #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .avm         (bus),
        .busy        (busy),
        .done        (done),
        .id_ok       (id_ok),
        .ts_ok       (ts_ok),
        .timeout_err (timeout_err),
        .id_value    (id_value),
        .ts_value    (ts_value),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    int    wait_id [4];
    int    wait_ts [4];
    word_t dat_id [4];
    word_t dat_ts [4];
    word_t m_id = '0;
    word_t m_ts = '0;
    int    run_gen = 0;

    // Slave: per attempt, stall each read for the planned number of cycles, then return the planned word.
    int   seen_gen = 0;
    int   attempt = -1;
    int   stall = 0;
    int   ai;
    bit   active = 0;
    logic cur_addr = 1'b0;
    bit   wr = 0;

    always @(negedge clk) begin
        if (run_gen != seen_gen) begin
            seen_gen = run_gen;
            attempt  = -1;
            active   = 0;
        end
        if (!bus.avm_read) begin
            active = 0;
            wr     = 0;
        end else begin
            if (active && bus.avm_address == cur_addr) begin
                if (wr) stall++;
            end else begin
                if (!active && bus.avm_address == SYSID_ADDR_ID) attempt++;
                active   = 1;
                cur_addr = bus.avm_address;
                stall    = 0;
            end
            ai = (attempt < 0) ? 0 : (attempt > 3 ? 3 : attempt);
            wr = stall < (cur_addr ? wait_ts[ai] : wait_id[ai]);
        end
        bus.avm_waitrequest = wr;
        bus.avm_readdata    = wr ? word_t'($urandom) : (cur_addr ? dat_ts[ai] : dat_id[ai]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input int wi, input int wt, input word_t di, input word_t dt);
        for (int a = 0; a < 4; a++) begin
            wait_id[a] = wi; wait_ts[a] = wt; dat_id[a] = di; dat_ts[a] = dt;
        end
    endtask

    // Whole-run outcome: read cycles, edge of done, final flags and retries used.
    task automatic model(output int edges, output int rd, output bit eid, output bit ets,
                         output bit eto, output int erc);
        rd = 0; eid = 0; ets = 0; eto = 0; erc = 0;
        for (int a = 0; a < ATTEMPTS; a++) begin
            eto = 0;
            erc = a;
            if (wait_id[a] >= TMO) begin
                rd += TMO; eto = 1;
            end else begin
                rd += wait_id[a] + 1; m_id = dat_id[a];
                if (wait_ts[a] >= TMO) begin
                    rd += TMO; eto = 1;
                end else begin
                    rd += wait_ts[a] + 1; m_ts = dat_ts[a];
                end
            end
            eid = !eto && (m_id == EXP_ID);
            ets = !eto && (m_ts == EXP_TS);
            if (eid && ets) break;
        end
        edges = rd + (erc + 1) + erc;
    endtask

    task automatic run(input bit auto_run, input int pulse_at, input bit start_at_done);
        int edges, rd, erc, n, rdcnt;
        bit eid, ets, eto, seen;
        model(edges, rd, eid, ets, eto, erc);
        run_gen++;
        @(negedge clk);
        if (auto_run) reset = 1'b0;
        else start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0; rdcnt = 0; seen = 0;
        while (n < 400 && !seen) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
            start = (n == pulse_at) && !seen;
            if (bus.avm_read) rdcnt++;
        end
        chk("done_seen", 32'(seen), 1);
        if (seen) begin
            chk("done_edge", n - 1, edges);
            chk("rd_cycles", rdcnt, rd);
            chk("id_ok", 32'(id_ok), 32'(eid));
            chk("ts_ok", 32'(ts_ok), 32'(ets));
            chk("timeout_err", 32'(timeout_err), 32'(eto));
            chk("id_value", id_value, m_id);
            chk("ts_value", ts_value, m_ts);
            chk("retry_count", 32'(retry_count), erc);
            chk("busy_at_done", 32'(busy), 0);
            start = start_at_done;
            @(negedge clk);
            start = 1'b0;
            chk("done_one_cycle", 32'(done), 0);
            chk("idle_after_done", 32'(busy), 0);
            chk("flags_held", 32'({id_ok, ts_ok}), 32'({eid, ets}));
        end
    endtask

    initial begin
        set_all(0, 0, EXP_ID, EXP_TS);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_read", 32'(bus.avm_read), 0);
        chk("rst_addr", 32'(bus.avm_address), 0);
        chk("rst_flags", 32'({id_ok, ts_ok, timeout_err}), 0);
        chk("rst_values", id_value | ts_value, 0);
        chk("rst_retry", 32'(retry_count), 0);

        run(1, 0, 0);                              // auto-run after reset, zero-wait
        set_all(0, 0, EXP_ID, 32'd0);
        run(0, 0, 0);                              // timestamp mismatch
        set_all(TMO + 6, 0, EXP_ID, EXP_TS);
        run(0, 0, 0);                              // waitrequest stuck on the ID read
        set_all(1, TMO + 2, EXP_ID, EXP_TS);
        run(0, 0, 0);                              // timeout on the timestamp read
        set_all(0, 0, 32'h1234_5678, 32'd7);
        dat_id[2] = EXP_ID; dat_ts[2] = EXP_TS;
        dat_id[3] = EXP_ID; dat_ts[3] = EXP_TS;
        run(0, 0, 0);                              // two bad attempts, then good
        set_all(0, 0, EXP_ID, EXP_TS);
        run(0, 2, 0);                              // start during RD_TS is dropped
        run(0, 0, 1);                              // start alongside done is dropped
        run(0, 0, 0);                              // next start is accepted

        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 4; a++) begin
                wait_id[a] = ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(0, 2));
                wait_ts[a] = ($urandom_range(0, 7) == 0) ? TMO + 1 : int'($urandom_range(0, 2));
                dat_id[a]  = ($urandom_range(0, 3) == 0) ? word_t'($urandom) : EXP_ID;
                dat_ts[a]  = ($urandom_range(0, 3) == 0) ? word_t'($urandom) : EXP_TS;
            end
            run(0, (r == 2) ? 2 : 0, r == 5);
        end

        set_all(3, 0, EXP_ID, EXP_TS);
        run_gen++;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rd_read", 32'(bus.avm_read), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_read_drop", 32'(bus.avm_read), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_values", id_value | ts_value, 0);
        chk("async_flags", 32'({done, id_ok, ts_ok, timeout_err}), 0);
        m_id = '0; m_ts = '0;
        set_all(1, 2, EXP_ID, EXP_TS);
        run(1, 0, 0);                              // fresh auto-run after reset

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
